// File: rtl/ram_sp_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous RAM.
// Each access takes IDLE -> ISSUE (-> RDATA for reads); every output is registered.
module ram_sp_arbiter #(
  parameter int add_size  = 10,
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [add_size-1:0]  addr0,
  input  logic [word_size-1:0] wdata0,
  output logic                 gnt0,
  output logic [word_size-1:0] rdata0,
  output logic                 rvalid0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [add_size-1:0]  addr1,
  input  logic [word_size-1:0] wdata1,
  output logic                 gnt1,
  output logic [word_size-1:0] rdata1,
  output logic                 rvalid1,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [add_size-1:0]  mem_addr,
  output logic [word_size-1:0] mem_din,
  input  logic [word_size-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 last_grant_reg, last_grant_next;
  logic                 port_reg, port_next;
  logic                 we_reg, we_next;
  logic [1:0]           gnt_reg, gnt_next;
  logic [1:0]           rvalid_reg, rvalid_next;
  logic                 mem_cs_reg, mem_cs_next;
  logic                 mem_we_reg, mem_we_next;
  logic                 mem_re_reg, mem_re_next;
  logic [add_size-1:0]  mem_addr_reg, mem_addr_next;
  logic [word_size-1:0] mem_din_reg, mem_din_next;
  logic [word_size-1:0] rdata_reg [2];
  logic [word_size-1:0] rdata_next [2];

  logic [1:0]           req_vec;
  logic [1:0]           we_vec;
  logic [add_size-1:0]  addr_vec [2];
  logic [word_size-1:0] wdata_vec [2];
  logic                 winner;

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // A lone requester wins; on contention the port not granted last time wins.
  always_comb begin
    winner = req_vec[1];
    if (req_vec == 2'b11) begin
      winner = ~last_grant_reg;
    end
  end

  // Read return path: the word captured in RDATA goes only to the issuing port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign rvalid_next[gi] = (state_reg == RDATA) && (port_reg == 1'(gi));
    assign rdata_next[gi]  = rvalid_next[gi] ? mem_dout : rdata_reg[gi];
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    port_next       = port_reg;
    we_next         = we_reg;
    gnt_next        = 2'b00;
    mem_cs_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_re_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_din_next    = mem_din_reg;

    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          port_next        = winner;
          we_next          = we_vec[winner];
          last_grant_next  = winner;
          gnt_next[winner] = 1'b1;
          mem_cs_next      = 1'b1;
          mem_we_next      = we_vec[winner];
          mem_re_next      = ~we_vec[winner];
          mem_addr_next    = addr_vec[winner];
          mem_din_next     = wdata_vec[winner];
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        state_next = we_reg ? IDLE : RDATA;
      end
      RDATA: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      we_reg         <= 1'b0;
      gnt_reg        <= 2'b00;
      rvalid_reg     <= 2'b00;
      mem_cs_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_re_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      rdata_reg[0]   <= '0;
      rdata_reg[1]   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      port_reg       <= port_next;
      we_reg         <= we_next;
      gnt_reg        <= gnt_next;
      rvalid_reg     <= rvalid_next;
      mem_cs_reg     <= mem_cs_next;
      mem_we_reg     <= mem_we_next;
      mem_re_reg     <= mem_re_next;
      mem_addr_reg   <= mem_addr_next;
      mem_din_reg    <= mem_din_next;
      rdata_reg[0]   <= rdata_next[0];
      rdata_reg[1]   <= rdata_next[1];
    end
  end

  assign gnt0     = gnt_reg[0];
  assign gnt1     = gnt_reg[1];
  assign rvalid0  = rvalid_reg[0];
  assign rvalid1  = rvalid_reg[1];
  assign rdata0   = rdata_reg[0];
  assign rdata1   = rdata_reg[1];
  assign mem_cs   = mem_cs_reg;
  assign mem_we   = mem_we_reg;
  assign mem_re   = mem_re_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: behavioural 1024x8 RAM, directed table, corner sequences
// and a randomized two-client run checked against a cycle-budget/scoreboard model.
module tb_ram_sp_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_cs, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sp_arbiter #(.add_size(AW), .word_size(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Single-port RAM with synchronous write and registered read; pre_en is a bench backdoor.
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      if (mem_re) mem_dout <= ram[mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rq, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = rq; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = rq; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick;
    pre_en = 1'b0;
  endtask

  // One access from an idle arbiter: gnt in cycle 1, rvalid/rdata in cycle 3 for reads.
  task automatic do_access(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    set_port(p, 1'b1, w, a, d);
    tick;
    chk($sformatf("acc p%0d gnt", p), (p == 1) ? gnt1 : gnt0, 1);
    chk($sformatf("acc p%0d other gnt", p), (p == 1) ? gnt0 : gnt1, 0);
    chk($sformatf("acc p%0d mem_cs", p), mem_cs, 1);
    chk($sformatf("acc p%0d mem_we", p), mem_we, w);
    chk($sformatf("acc p%0d mem_re", p), mem_re, !w);
    chk($sformatf("acc p%0d mem_addr", p), mem_addr, a);
    if (w) chk($sformatf("acc p%0d mem_din", p), mem_din, d);
    set_port(p, 1'b0, w, a, d);
    tick;
    $display("access port=%0d we=%0d addr=0x%03h wdata=0x%02h", p, w, a, d);
    if (!w) begin
      chk($sformatf("acc p%0d early rvalid", p), (p == 1) ? rvalid1 : rvalid0, 0);
      tick;
      chk($sformatf("acc p%0d rvalid", p), (p == 1) ? rvalid1 : rvalid0, 1);
      chk($sformatf("acc p%0d rdata", p), (p == 1) ? rdata1 : rdata0, exp_rd);
      chk($sformatf("acc p%0d other rvalid", p), (p == 1) ? rvalid0 : rvalid1, 0);
      $display("  read returned 0x%02h", (p == 1) ? rdata1 : rdata0);
    end
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int last_gp, ngnt, nrv, cyc, free_from, model_last, gp, exp_p;
    logic [AW-1:0] keep_addr;
    logic rr [2];
    logic rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    int due [2];
    logic [DW-1:0] due_data [2];

    tbl[0] = '{0, 1'b1, 10'h012, 8'hA5, 8'h00};
    tbl[1] = '{0, 1'b0, 10'h012, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 10'h000, 8'h5A, 8'h00};
    tbl[3] = '{1, 1'b0, 10'h000, 8'h00, 8'h5A};
    tbl[4] = '{0, 1'b0, 10'h000, 8'h00, 8'h5A};
    tbl[5] = '{0, 1'b1, 10'h3FE, 8'hFF, 8'h00};
    tbl[6] = '{1, 1'b0, 10'h3FE, 8'h00, 8'hFF};

    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, '0, '0);

    // Reset held two cycles with both requests high.
    tick;
    tick;
    chk("rst gnt0", gnt0, 0);       chk("rst gnt1", gnt1, 0);
    chk("rst rvalid0", rvalid0, 0); chk("rst rvalid1", rvalid1, 0);
    chk("rst mem_cs", mem_cs, 0);   chk("rst mem_we", mem_we, 0);
    chk("rst mem_re", mem_re, 0);   chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);   chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_din", mem_din, 0);
    rst = 1'b0;
    tick;
    chk("first contest gnt0", gnt0, 1);
    chk("first contest gnt1", gnt1, 0);
    $display("reset released: gnt0=%0d gnt1=%0d", gnt0, gnt1);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick;
    tick;

    for (int i = 0; i < 7; i++)
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

    // Both ports stream reads: grants must alternate, one every 3 cycles.
    preload(10'h001, 8'h11);
    preload(10'h002, 8'h22);
    set_port(0, 1'b1, 1'b0, 10'h001, '0);
    set_port(1, 1'b1, 1'b0, 10'h002, '0);
    last_gp = -1; ngnt = 0; nrv = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      chk("alt no double gnt", gnt0 & gnt1, 0);
      if (gnt0 | gnt1) begin
        gp = gnt1 ? 1 : 0;
        if (last_gp >= 0) chk("alt grant alternates", gp, 1 - last_gp);
        last_gp = gp;
        ngnt++;
        $display("alt grant port=%0d", gp);
      end
      if (rvalid0) begin chk("alt rdata0", rdata0, 8'h11); nrv++; end
      if (rvalid1) begin chk("alt rdata1", rdata1, 8'h22); nrv++; end
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    chk("alt grant count", ngnt, 4);
    chk("alt rvalid count", nrv, 4);
    tick;

    // Port 1 writes the top address while port 0 waits to read it.
    set_port(1, 1'b1, 1'b1, 10'h3FF, 8'h3C);
    tick;
    chk("wrap gnt1", gnt1, 1);
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b0, 10'h3FF, '0);
    tick;
    chk("wrap p0 waits", gnt0, 0);
    tick;
    chk("wrap gnt0", gnt0, 1);
    chk("wrap mem_re", mem_re, 1);
    set_port(0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;
    chk("wrap rvalid0", rvalid0, 1);
    chk("wrap rdata0", rdata0, 8'h3C);
    $display("wrap read 0x3FF returned 0x%02h", rdata0);

    // Reset during RDATA of a port 1 read.
    set_port(1, 1'b1, 1'b0, 10'h002, '0);
    tick;
    chk("rstrd gnt1", gnt1, 1);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstrd rvalid1", rvalid1, 0);
    chk("rstrd rdata1", rdata1, 0);
    chk("rstrd mem_cs", mem_cs, 0);
    set_port(0, 1'b1, 1'b0, 10'h001, '0);
    set_port(1, 1'b1, 1'b0, 10'h002, '0);
    tick;
    chk("rstrd idle gnt0", gnt0, 1);
    chk("rstrd idle gnt1", gnt1, 0);
    chk("rstrd late rvalid1", rvalid1, 0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick;
    chk("rstrd rvalid1 quiet", rvalid1, 0);
    tick;
    chk("rstrd p0 rdata", rdata0, 8'h11);
    $display("reset during read: rvalid1=%0d rdata1=0x%02h", rvalid1, rdata1);

    // Idle bus.
    keep_addr = mem_addr;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("idle mem_cs", mem_cs, 0);
      chk("idle mem_we", mem_we, 0);
      chk("idle mem_re", mem_re, 0);
      chk("idle mem_addr", mem_addr, keep_addr);
    end
    $display("idle bus: 10 cycles, mem_addr=0x%03h", mem_addr);

    // Randomized phase: 16-word pool at 0x100 so both ports collide often.
    for (int i = 0; i < 16; i++) begin
      ref_mem[10'h100 + i] = 8'($urandom);
      preload(10'(10'h100 + i), ref_mem[10'h100 + i]);
    end
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rr[p] = 1'b0; rw[p] = 1'b0; ra[p] = '0; rd[p] = '0;
      due[p] = -1; due_data[p] = '0;
      set_port(p, 1'b0, 1'b0, '0, '0);
    end
    tick;
    rst = 1'b0;
    cyc = 0; free_from = 0; model_last = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rr[p] && $urandom_range(0, 2) == 0) begin
          rr[p] = 1'b1;
          rw[p] = 1'($urandom_range(0, 1));
          ra[p] = 10'(10'h100 + $urandom_range(0, 15));
          rd[p] = 8'($urandom);
        end
        set_port(p, rr[p], rw[p], ra[p], rd[p]);
      end
      tick;
      cyc++;
      chk("rnd no double gnt", gnt0 & gnt1, 0);
      chk("rnd we/re exclusive", mem_we & mem_re, 0);
      chk("rnd grant expected", gnt0 | gnt1,
          ((cyc - 1) >= free_from) && (rr[0] || rr[1]));
      if (gnt0 | gnt1) begin
        gp = gnt1 ? 1 : 0;
        exp_p = (rr[0] && rr[1]) ? 1 - model_last : (rr[1] ? 1 : 0);
        chk("rnd grant port", gp, exp_p);
        chk("rnd mem_cs", mem_cs, 1);
        chk("rnd mem_we", mem_we, rw[gp]);
        chk("rnd mem_addr", mem_addr, ra[gp]);
        if (rw[gp]) begin
          chk("rnd mem_din", mem_din, rd[gp]);
          ref_mem[ra[gp]] = rd[gp];
          free_from = cyc + 1;
        end else begin
          due[gp] = cyc + 2;
          due_data[gp] = ref_mem[ra[gp]];
          free_from = cyc + 2;
        end
        $display("rnd cyc=%0d grant port=%0d we=%0d addr=0x%03h", cyc, gp, rw[gp], ra[gp]);
        model_last = gp;
        rr[gp] = 1'b0;
      end else begin
        chk("rnd mem_cs idle", mem_cs, 0);
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rnd rvalid%0d", p), (p == 1) ? rvalid1 : rvalid0, due[p] == cyc);
        if (due[p] == cyc) begin
          chk($sformatf("rnd rdata%0d", p), (p == 1) ? rdata1 : rdata0, due_data[p]);
          due[p] = -1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
